// File: rtl/reg_file_sb_if.sv
// Port bundle for reg_file_sb: read ports, write ports, allocation request and busy vector.
// The slave modport is the register file's view; the master modport is the issuing logic's view.
interface reg_file_sb_if #(
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
);
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_RD-1:0]             rd_vld;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;
  logic [NUM_WR-1:0]             wr_vld;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
  logic                          alloc_vld;
  logic [ADDR_W-1:0]             alloc_addr;
  logic [NUM_REGS-1:0]           busy_vec;

  modport slave (
    input  rd_vld, rd_addr, wr_vld, wr_addr, wr_data, alloc_vld, alloc_addr,
    output rd_data, rd_busy, busy_vec
  );

  modport master (
    output rd_vld, rd_addr, wr_vld, wr_addr, wr_data, alloc_vld, alloc_addr,
    input  rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with a one-bit-per-register scoreboard (busy = result pending).
// Optional macro REG_FILE_SB_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_sb #(
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic          clk,
  input  logic          resetn,
  reg_file_sb_if.slave  bus
);
  localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0]   reg_data [NUM_REGS];
  logic [NUM_REGS-1:0] busy_bits;

  // Storage is flop-based: every register and busy bit must clear asynchronously.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_data[gi]  = '0;
        assign busy_bits[gi] = 1'b0;
      end else begin : g_store
        logic [DATA_W-1:0] data_reg;
        logic              busy_reg;
        logic [DATA_W-1:0] data_next;
        logic              wr_hit;
        logic              alloc_hit;

        // Later ports overwrite earlier ones, so the highest-indexed writer wins.
        always_comb begin
          wr_hit    = 1'b0;
          data_next = data_reg;
          for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_vld[p] && (bus.wr_addr[p] == ADDR_W'(gi))) begin
              wr_hit    = 1'b1;
              data_next = bus.wr_data[p];
            end
          end
        end

        assign alloc_hit = bus.alloc_vld && (bus.alloc_addr == ADDR_W'(gi));

        // A new allocation outranks the completing write: the new producer still owes a value.
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            data_reg <= '0;
            busy_reg <= 1'b0;
          end else begin
            if (wr_hit) begin
              data_reg <= data_next;
            end
            if (alloc_hit) begin
              busy_reg <= 1'b1;
            end else if (wr_hit) begin
              busy_reg <= 1'b0;
            end
          end
        end

        assign reg_data[gi]  = data_reg;
        assign busy_bits[gi] = busy_reg;
      end
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic              rd_ok;
      logic [DATA_W-1:0] rd_val;
      logic              rd_pend;

      always_comb begin
        rd_val  = '0;
        rd_pend = 1'b0;
        rd_ok   = bus.rd_vld[gi] && (bus.rd_addr[gi] != '0) &&
                  (32'(bus.rd_addr[gi]) < NUM_REGS);
        if (rd_ok) begin
          rd_val  = reg_data[bus.rd_addr[gi]];
          rd_pend = busy_bits[bus.rd_addr[gi]];
`ifdef REG_FILE_SB_BYPASS_EN
          for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_vld[p] && (bus.wr_addr[p] == bus.rd_addr[gi])) begin
              rd_val  = bus.wr_data[p];
              rd_pend = bus.alloc_vld && (bus.alloc_addr == bus.rd_addr[gi]);
            end
          end
`endif
        end
      end

      assign bus.rd_data[gi] = rd_val;
      assign bus.rd_busy[gi] = rd_pend;
    end
  endgenerate

  assign bus.busy_vec = busy_bits;
endmodule
